// File: rtl/module_prio_sel.sv
// Priority selector: shows the data of the highest-index ready channel.
// MODE 0 follows the live ch_listo levels; MODE 1 locks on rising edges until clr.
module module_prio_sel #(
  parameter int WIDTH = 16,
  parameter int N_CH  = 3,
  parameter int MODE  = 1,
  localparam int SEL_W = ($clog2(N_CH) < 1) ? 1 : $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH*WIDTH-1:0]   ch_data,
  input  logic [N_CH-1:0]         ch_listo,
  input  logic                    clr,
  output logic [WIDTH-1:0]        numero_output,
  output logic [SEL_W-1:0]        sel_ch,
  output logic                    out_valid,
  output logic                    nuevo
);

  typedef enum logic {IDLE, LOCKED} state_t;

  typedef struct packed {
    logic             hit;
    logic [SEL_W-1:0] idx;
  } pick_t;

  state_t           state_q, state_d;
  logic [N_CH-1:0]  listo_q, listo_d;
  logic [WIDTH-1:0] numero_q, numero_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             nuevo_q, nuevo_d;
  logic [N_CH-1:0]  rise;
  pick_t            lvl_pick, rise_pick;

  // Highest set bit wins, so later loop iterations overwrite earlier ones.
  function automatic pick_t top_idx(input logic [N_CH-1:0] v);
    pick_t p;
    p = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (v[k]) begin
        p.hit = 1'b1;
        p.idx = SEL_W'(k);
      end
    end
    return p;
  endfunction

  assign rise      = ch_listo & ~listo_q;
  assign lvl_pick  = top_idx(ch_listo);
  assign rise_pick = top_idx(rise);

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d  = state_q;
    listo_d  = ch_listo;
    numero_d = numero_q;
    sel_d    = sel_q;
    valid_d  = valid_q;

    if (MODE == 0) begin
      if (lvl_pick.hit) begin
        numero_d = ch_data[int'(lvl_pick.idx)*WIDTH +: WIDTH];
        sel_d    = lvl_pick.idx;
        valid_d  = 1'b1;
      end else begin
        valid_d  = 1'b0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise_pick.hit) begin
            numero_d = ch_data[int'(rise_pick.idx)*WIDTH +: WIDTH];
            sel_d    = rise_pick.idx;
            valid_d  = 1'b1;
            state_d  = LOCKED;
          end
        end
        LOCKED: begin
          // Lower-index edges cannot displace the locked channel.
          if (rise_pick.hit && (rise_pick.idx >= sel_q)) begin
            numero_d = ch_data[int'(rise_pick.idx)*WIDTH +: WIDTH];
            sel_d    = rise_pick.idx;
            valid_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // clr overrides any capture; listo_d still follows the input so a held level
    // is not seen as a fresh edge afterwards.
    if (clr) begin
      numero_d = '0;
      sel_d    = '0;
      valid_d  = 1'b0;
      state_d  = IDLE;
    end

    nuevo_d = (numero_d != numero_q) || (sel_d != sel_q);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      listo_q  <= '0;
      numero_q <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      nuevo_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      listo_q  <= listo_d;
      numero_q <= numero_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      nuevo_q  <= nuevo_d;
    end
  end

  assign numero_output = numero_q;
  assign sel_ch        = sel_q;
  assign out_valid     = valid_q;
  assign nuevo         = nuevo_q;

endmodule

// File: tb/tb_module_prio_sel.sv
// Bench for module_prio_sel: a MODE 1 and a MODE 0 instance share stimulus;
// each vector names the instance it checks.
module tb_module_prio_sel;
  localparam int WIDTH = 16;
  localparam int N_CH  = 3;
  localparam int SEL_W = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  clr = 1'b0;
  logic [N_CH-1:0]       listo = '0;
  logic [N_CH*WIDTH-1:0] data = {16'd150, 16'd10, 16'd15};

  logic [WIDTH-1:0] out0, out1;
  logic [SEL_W-1:0] sel0, sel1;
  logic             val0, val1, nu0, nu1;

  module_prio_sel #(.WIDTH(WIDTH), .N_CH(N_CH), .MODE(0)) u_lvl (
    .clk(clk), .rst(rst), .ch_data(data), .ch_listo(listo), .clr(clr),
    .numero_output(out0), .sel_ch(sel0), .out_valid(val0), .nuevo(nu0));

  module_prio_sel #(.WIDTH(WIDTH), .N_CH(N_CH), .MODE(1)) u_stk (
    .clk(clk), .rst(rst), .ch_data(data), .ch_listo(listo), .clr(clr),
    .numero_output(out1), .sel_ch(sel1), .out_valid(val1), .nuevo(nu1));

  always #5 clk = ~clk;

  typedef struct {
    int         which;
    logic [2:0] listo;
    logic [15:0] d0, d1, d2;
    logic       clr;
    logic [15:0] e_out;
    logic [1:0] e_sel;
    logic       e_val;
    logic       e_nu;
    string      name;
  } vec_t;

  typedef struct {
    int         which;
    logic [15:0] out;
    logic [1:0] sel;
    logic       val;
    logic       nu;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_part_a;

  function automatic vec_t mk(int which, logic [2:0] l, logic [15:0] d0, logic [15:0] d1,
                              logic [15:0] d2, logic c, logic [15:0] eo, logic [1:0] es,
                              logic ev, logic en, string name);
    vec_t v;
    v.which = which; v.listo = l; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.clr = c;
    v.e_out = eo; v.e_sel = es; v.e_val = ev; v.e_nu = en; v.name = name;
    return v;
  endfunction

  function automatic exp_t mke(int which, logic [15:0] o, logic [1:0] s, logic v, logic n,
                               string name);
    exp_t e;
    e.which = which; e.out = o; e.sel = s; e.val = v; e.nu = n; e.name = name;
    return e;
  endfunction

  task automatic check(input exp_t e);
    logic [15:0] go;
    logic [1:0]  gs;
    logic        gv, gn;
    if (e.which == 0) begin
      go = out0; gs = sel0; gv = val0; gn = nu0;
    end else begin
      go = out1; gs = sel1; gv = val1; gn = nu1;
    end
    n_tests++;
    if (go !== e.out || gs !== e.sel || gv !== e.val || gn !== e.nu) begin
      n_fail++;
      $display("FAIL %s (mode%0d): got out=%0d sel=%0d valid=%0b nuevo=%0b, want out=%0d sel=%0d valid=%0b nuevo=%0b",
               e.name, (e.which == 0) ? 0 : 1, go, gs, gv, gn, e.out, e.sel, e.val, e.nu);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    listo = v.listo;
    data  = {v.d2, v.d1, v.d0};
    clr   = v.clr;
    sb.push_back(mke(v.which, v.e_out, v.e_sel, v.e_val, v.e_nu, v.name));
    @(posedge clk);
    #1;
    check(sb.pop_front());
  endtask

  initial begin
    // Part A: sticky instance (plus one level-mode idle check).
    vecs.push_back(mk(1, 3'b000, 15, 10, 150, 0,   0, 0, 0, 0, "idle_stk"));
    vecs.push_back(mk(0, 3'b000, 15, 10, 150, 0,   0, 0, 0, 0, "idle_lvl"));
    vecs.push_back(mk(1, 3'b001, 15, 10, 150, 0,  15, 0, 1, 1, "edge_ch0"));
    vecs.push_back(mk(1, 3'b011, 15, 10, 150, 0,  10, 1, 1, 1, "edge_ch1"));
    vecs.push_back(mk(1, 3'b111, 15, 10, 150, 0, 150, 2, 1, 1, "edge_ch2"));
    vecs.push_back(mk(1, 3'b111, 15, 10, 150, 0, 150, 2, 1, 0, "hold_ch2"));
    vecs.push_back(mk(1, 3'b110, 99, 10, 150, 0, 150, 2, 1, 0, "ch0_fall"));
    vecs.push_back(mk(1, 3'b111, 99, 10, 150, 0, 150, 2, 1, 0, "low_edge_ignored"));
    vecs.push_back(mk(1, 3'b111, 99, 10,  77, 0, 150, 2, 1, 0, "data_chg_no_edge"));
    vecs.push_back(mk(1, 3'b000, 15, 10, 150, 0, 150, 2, 1, 0, "fall_keeps_lock"));
    vecs.push_back(mk(1, 3'b100, 15, 10, 150, 0, 150, 2, 1, 0, "same_recapture"));
    vecs.push_back(mk(1, 3'b000, 15, 10, 151, 0, 150, 2, 1, 0, "drop_ch2"));
    vecs.push_back(mk(1, 3'b100, 15, 10, 151, 0, 151, 2, 1, 1, "refresh_ch2"));
    vecs.push_back(mk(1, 3'b000, 15, 10, 150, 1,   0, 0, 0, 1, "clr_lock"));
    vecs.push_back(mk(1, 3'b000, 15, 10, 150, 0,   0, 0, 0, 0, "after_clr"));
    vecs.push_back(mk(1, 3'b111, 15, 10, 150, 0, 150, 2, 1, 1, "simul_edges"));
    vecs.push_back(mk(1, 3'b101, 15, 10, 150, 0, 150, 2, 1, 0, "ch1_drop"));
    vecs.push_back(mk(1, 3'b111, 15, 10, 150, 1,   0, 0, 0, 1, "clr_beats_edge"));
    vecs.push_back(mk(1, 3'b111, 15, 10, 150, 0,   0, 0, 0, 0, "no_retrigger"));
    vecs.push_back(mk(1, 3'b111, 15, 10, 150, 1,   0, 0, 0, 0, "clr_idle_quiet"));
    vecs.push_back(mk(1, 3'b000, 15, 10, 150, 0,   0, 0, 0, 0, "release_all"));
    vecs.push_back(mk(1, 3'b111, 15, 10, 150, 0, 150, 2, 1, 1, "relock"));
    n_part_a = vecs.size();
    // Part B: level instance, run after the reset sequence.
    vecs.push_back(mk(0, 3'b110, 15, 10, 150, 0, 150, 2, 1, 0, "lvl_hold"));
    vecs.push_back(mk(0, 3'b110, 15, 10, 151, 0, 151, 2, 1, 1, "lvl_track"));
    vecs.push_back(mk(0, 3'b010, 15, 10, 151, 0,  10, 1, 1, 1, "lvl_drop_ch2"));
    vecs.push_back(mk(0, 3'b000, 15, 10, 151, 0,  10, 1, 0, 0, "lvl_none"));
    vecs.push_back(mk(0, 3'b001, 15, 10, 151, 0,  15, 0, 1, 1, "lvl_ch0"));
    vecs.push_back(mk(0, 3'b111, 15, 10, 150, 1,   0, 0, 0, 1, "lvl_clr"));
    vecs.push_back(mk(0, 3'b100, 15, 10, 150, 0, 150, 2, 1, 1, "lvl_ch2"));

    // Reset held across the first edge.
    @(posedge clk);
    #1;
    check(mke(1, 0, 0, 0, 0, "reset_stk"));
    check(mke(0, 0, 0, 0, 0, "reset_lvl"));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < n_part_a; i++) apply(vecs[i]);

    // Mid-lock reset with 111 held: async clear, then capture on first edge after release.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check(mke(1, 0, 0, 0, 0, "rst_async"));
    @(posedge clk);
    #1;
    check(mke(1, 0, 0, 0, 0, "rst_held_stk"));
    check(mke(0, 0, 0, 0, 0, "rst_held_lvl"));
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(mke(1, 150, 2, 1, 1, "rst_release_capture"));
    @(posedge clk);
    #1;
    check(sb.pop_front());

    for (int i = n_part_a; i < vecs.size(); i++) apply(vecs[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/module_prio_sel.md
MODULE_PRIO_SEL -- requirements
Module: module_prio_sel

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16: width of every data channel and of the output.
REQ-002 The block SHALL take parameter N_CH, default 3: number of input channels, legal range 2..8.
REQ-003 The block SHALL take parameter MODE, default 1: 0 = level priority, 1 = sticky (latched) priority.
REQ-004 The block SHALL have port clk, input, 1 bit: single system clock, rising edge active.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port ch_data, input, N_CH*WIDTH bits: channel k data at bits [k*WIDTH +: WIDTH].
REQ-007 The block SHALL have port ch_listo, input, N_CH bits: channel k ready flag, level-held by the source.
REQ-008 The block SHALL have port clr, input, 1 bit: synchronous clear of the displayed value and any lock.
REQ-009 The block SHALL have port numero_output, output, WIDTH bits: selected channel data, registered.
REQ-010 The block SHALL have port sel_ch, output, max(1,$clog2(N_CH)) bits: index of the channel currently shown.
REQ-011 The block SHALL have port out_valid, output, 1 bit: high while numero_output holds channel data.
REQ-012 The block SHALL have port nuevo, output, 1 bit: one-cycle pulse in the cycle after numero_output or sel_ch changes.

Function
REQ-013 Priority SHALL be by index, highest index wins (channel N_CH-1 highest).
REQ-014 All outputs SHALL be registered, with 1-cycle latency from a sampled input to the output.
REQ-015 MODE 0: each cycle, the block SHALL register the data and index of the highest-index channel with ch_listo high; with none high, out_valid=0 and numero_output holds its last value.
REQ-016 MODE 0: numero_output SHALL track live changes of the selected channel's ch_data while its ch_listo stays high.
REQ-017 MODE 1: the block SHALL keep a registered copy of ch_listo and detect per-channel rising edges (0->1).
REQ-018 MODE 1 FSM SHALL have states IDLE (nothing shown) and LOCKED (sel_ch captured).
REQ-019 IDLE -> LOCKED SHALL occur on any rising edge; the block captures the highest-index edge channel's data and index.
REQ-020 In LOCKED, a rising edge on channel k >= sel_ch SHALL recapture; equal index refreshes the data.
REQ-021 In LOCKED, edges on k < sel_ch SHALL be ignored, and data changes on the locked channel without a new edge SHALL not update the output.
REQ-022 LOCKED -> IDLE SHALL occur only on clr; falling ch_listo SHALL not release the lock.
REQ-023 Simultaneous rising edges SHALL resolve to the highest index in the same cycle.
REQ-024 clr in the same cycle as an edge: clr SHALL win and the edge is discarded; the edge register still updates, so the same level does not re-trigger.
REQ-025 clr SHALL force numero_output=0, sel_ch=0, out_valid=0, and IDLE; nuevo SHALL pulse only if the output changed.
REQ-026 nuevo SHALL not pulse when a recapture yields an identical data and index.
REQ-027 The block SHALL perform no arithmetic on data: channel data passes bit-exact, with no extension or truncation.

Reset
REQ-028 On rst high, outputs SHALL go immediately (asynchronously) to numero_output=0, sel_ch=0, out_valid=0, nuevo=0, and the FSM to IDLE.
REQ-029 On rst high, the edge-detect register SHALL be cleared to 0, so a ch_listo already high at reset release counts as a rising edge on the first clk.
REQ-030 rst asserted mid-lock SHALL abort the lock; no capture occurs while rst is high.

Verification (WIDTH=16, N_CH=3, MODE=1 unless noted; ch0=15, ch1=10, ch2=150)
REQ-031 Bench SHALL cover: rst high 10 ns then low, all listo=0 -> outputs all 0, nuevo never pulses.
REQ-032 Bench SHALL cover: ch_listo=001, then 011 one cycle later, then 111 -> numero_output 15, then 10, then 150; sel_ch 0,1,2; one nuevo pulse each.
REQ-033 Bench SHALL cover: locked on ch2=150, then ch0 listo 0->1 with ch0=99 -> output stays 150, sel_ch=2, no nuevo.
REQ-034 Bench SHALL cover: ch_listo 000 -> 111 in one cycle -> sel_ch=2, output 150 after 1 cycle; then clr with a ch1 edge in the same cycle -> output 0, out_valid 0, IDLE, ch1 not captured.
REQ-035 Bench SHALL cover: MODE=0, ch_listo=110, then ch2 data changes 150->151 -> output 150 then 151; ch_listo 110->010 -> output 10, sel_ch=1.
REQ-036 Bench SHALL cover: ch_listo=111 held through an rst pulse -> outputs 0 during rst; first clk after release captures ch2=150.
